modsub_arbiter: RTL and testbench

//   Shares one pipelined modsub instance (C = (A - B) mod q) between NREQ requesters.
//   - Round-robin arbitration: at most one operand pair issued per cycle.
//   - Each issue is tagged with its requester id.
//   - Credit-based output FIFO absorbs results, since the modsub pipeline cannot stall.
//   - Sits between the NTT/butterfly control units and the modular-arithmetic datapath.

---
 rtl/modsub_arbiter_if.sv | 28 ++
 rtl/modsub_arbiter.sv | 167 ++++++++++++++++
 tb/tb_modsub_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modsub_arbiter_if.sv
// Requester/response bundle for modsub_arbiter.
// master: requesters plus result consumer; slave: the arbiter.
interface modsub_arbiter_if #(
   parameter int NREQ = 4,
   parameter int LOGA = 64,
   parameter int LOGB = 64,
   parameter int LOGQ = 64,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*LOGA-1:0] req_a;
   logic [NREQ*LOGB-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [LOGQ-1:0]      rsp_c;
   logic [IDW-1:0]       rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_c, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_c, rsp_id
   );
endinterface

// File: rtl/modsub_arbiter.sv
// Round-robin front end sharing one pipelined (A - B) mod q unit,
// with a credit-guarded result FIFO behind the non-stallable pipe.

module modsub_arbiter_dly #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   if (N == 0) begin : g_wire
      assign q_o = d_i;
   end else begin : g_reg
      logic [W-1:0] r_q [N];
      always_ff @(posedge clk) begin
         r_q[0] <= d_i;
         for (int i = 1; i < N; i++) r_q[i] <= r_q[i-1];
      end
      assign q_o = r_q[N-1];
   end
endmodule

module modsub_arbiter #(
   parameter int LOGA       = 64,
   parameter int LOGB       = 64,
   parameter int LOGQ       = 64,
   parameter int LOGQH      = 47,
   parameter int FF_IN      = 1,
   parameter int FF_SUB     = 1,
   parameter int FF_OUT     = 1,
   parameter int NREQ       = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LOGQH-1:0] qH,
   output logic             busy,
   modsub_arbiter_if.slave  bus
);
   localparam int LAT = FF_IN + FF_SUB + FF_OUT;
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] CRED  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LASTP = PW'(FIFO_DEPTH - 1);

   logic [IDW-1:0] last_q, last_d, win;
   logic           found, issue, push, pop;
   logic [CW-1:0]  out_q, out_d, cnt_q, cnt_d;
   logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;

   // Search starts one past the last grant.
   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_q) + k) % NREQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign issue  = rst_n && found && (out_q < CRED);
   assign last_d = issue ? win : last_q;

   always_comb begin
      bus.req_ready = '0;
      if (issue) bus.req_ready[win] = 1'b1;
   end

   logic [LOGA+LOGB-1:0] ab_m, ab_p;
   logic [LOGQ-1:0]      q_w, a_x, b_x, c_w, c_p;
   logic [LOGQ:0]        s_w, s_p;

   assign ab_m = {bus.req_a[int'(win)*LOGA +: LOGA],
                  bus.req_b[int'(win)*LOGB +: LOGB]};

   modsub_arbiter_dly #(.W(LOGA+LOGB), .N(FF_IN)) u_in (
      .clk(clk), .d_i(ab_m), .q_o(ab_p)
   );

   assign q_w = {qH, {(LOGQ-LOGQH-1){1'b0}}, 1'b1};
   assign a_x = LOGQ'(ab_p[LOGA+LOGB-1:LOGB]);
   assign b_x = LOGQ'(ab_p[LOGB-1:0]);
   // Borrow travels with the raw difference; q is added a stage later.
   assign s_w = {a_x < b_x, a_x - b_x};

   modsub_arbiter_dly #(.W(LOGQ+1), .N(FF_SUB)) u_sub (
      .clk(clk), .d_i(s_w), .q_o(s_p)
   );

   assign c_w = s_p[LOGQ] ? s_p[LOGQ-1:0] + q_w : s_p[LOGQ-1:0];

   modsub_arbiter_dly #(.W(LOGQ), .N(FF_OUT)) u_out (
      .clk(clk), .d_i(c_w), .q_o(c_p)
   );

   logic [LAT-1:0] tv_q;
   logic [IDW-1:0] tid_q [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv_q <= '0;
         for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
      end else begin
         tv_q[0]  <= issue;
         tid_q[0] <= issue ? win : '0;
         for (int i = 1; i < LAT; i++) begin
            tv_q[i]  <= tv_q[i-1];
            tid_q[i] <= tid_q[i-1];
         end
      end
   end

   assign push          = tv_q[LAT-1];
   assign bus.rsp_valid = (cnt_q != '0);
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      out_d = out_q;
      if (push) wr_d = (wr_q == LASTP) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LASTP) ? '0 : rd_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (!push && pop) cnt_d = cnt_q - 1'b1;
      // A pop only returns its credit on the following cycle.
      if (issue && !pop) out_d = out_q + 1'b1;
      if (!issue && pop) out_d = out_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= IDW'(NREQ - 1);
         out_q  <= '0;
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
      end else begin
         last_q <= last_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
      end
   end

   logic [LOGQ-1:0] mc_q [FIFO_DEPTH];
   logic [IDW-1:0]  mi_q [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         mc_q[wr_q] <= c_p;
         mi_q[wr_q] <= tid_q[LAT-1];
      end
   end

   assign bus.rsp_c  = bus.rsp_valid ? mc_q[rd_q] : '0;
   assign bus.rsp_id = bus.rsp_valid ? mi_q[rd_q] : '0;
   assign busy       = (|tv_q) || (cnt_q != '0);
endmodule

// File: tb/tb_modsub_arbiter.sv
// Bench for modsub_arbiter: directed edges plus random traffic
// against a queue model of arbitration, credits and ordering.
module tb_modsub_arbiter;
   localparam int NREQ  = 4;
   localparam int DEPTH = 8;
   localparam int LAT   = 3;
   localparam int IDW   = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [46:0] qH    = 47'h400008C00000;
   logic        busy;
   int ntot = 0;
   int nfail = 0;
   int cyc = 0;

   modsub_arbiter_if #(
      .NREQ(NREQ), .LOGA(64), .LOGB(64), .LOGQ(64), .IDW(IDW)
   ) bus ();

   modsub_arbiter #(
      .LOGA(64), .LOGB(64), .LOGQ(64), .LOGQH(47),
      .FF_IN(1), .FF_SUB(1), .FF_OUT(1),
      .NREQ(NREQ), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .qH(qH), .busy(busy), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] c;
      int          id;
      int          due;
   } ent_t;

   ent_t pipe_q[$];
   ent_t fifo_q[$];
   int   last = NREQ - 1;
   logic [63:0]     va [NREQ];
   logic [63:0]     vb [NREQ];
   logic [NREQ-1:0] vv;
   logic [NREQ-1:0] hs;

   function automatic logic [63:0] modsub(input logic [63:0] a,
                                          input logic [63:0] b);
      logic [63:0] q;
      q = {qH, 16'h0000, 1'b1};
      return (a >= b) ? a - b : a - b + q;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] rnd_b(input logic [63:0] a);
      case ($urandom_range(0, 3))
         0: return rnd64();
         1: return a;
         2: return a + 64'($urandom_range(1, 9));
         default: return a - 64'($urandom_range(1, 9));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*64 +: 64] = va[i];
         bus.req_b[i*64 +: 64] = vb[i];
      end
      bus.req_valid = vv;
   endtask

   task automatic cycle();
      logic [NREQ-1:0] er;
      int   w;
      int   outst;
      bit   pp;
      ent_t e;
      @(negedge clk);
      w = -1;
      for (int k = 1; k <= NREQ; k++)
         if (w < 0 && vv[(last + k) % NREQ]) w = (last + k) % NREQ;
      outst = pipe_q.size() + fifo_q.size();
      er = '0;
      if (w >= 0 && outst < DEPTH) er[w] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) begin
         chk("rsp_c", bus.rsp_c, fifo_q[0].c);
         chk("rsp_id", 64'(bus.rsp_id), 64'(fifo_q[0].id));
      end
      chk("busy", 64'(busy), 64'(outst != 0));
      pp = (fifo_q.size() != 0) && bus.rsp_ready;
      hs = er;
      @(posedge clk);
      cyc++;
      if (pp) void'(fifo_q.pop_front());
      while (pipe_q.size() != 0 && pipe_q[0].due == cyc)
         fifo_q.push_back(pipe_q.pop_front());
      if (er != 0) begin
         e.c   = modsub(va[w], vb[w]);
         e.id  = w;
         e.due = cyc + LAT;
         pipe_q.push_back(e);
         last = w;
      end
      #1;
   endtask

   task automatic refresh(input bit rnd);
      for (int i = 0; i < NREQ; i++) begin
         if (hs[i] || !vv[i]) begin
            va[i] = rnd64();
            vb[i] = rnd_b(va[i]);
            vv[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      drive();
   endtask

   task automatic drain();
      vv = '0;
      hs = '0;
      drive();
      bus.rsp_ready = 1'b1;
      for (int n = 0; n < 40; n++)
         if (pipe_q.size() + fifo_q.size() != 0) cycle();
      chk("drain_bound", 64'(pipe_q.size() + fifo_q.size()), 64'd0);
      cycle();
   endtask

   task automatic single(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] c, output int lat);
      int t;
      va[0] = a;
      vb[0] = b;
      vv = 4'b0001;
      drive();
      cycle();
      chk("single_hs", 64'(hs), 64'h1);
      t = cyc - 1;
      vv = '0;
      drive();
      c = 'x;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (lat < 0) begin
            cycle();
            if (bus.rsp_valid) begin
               lat = cyc - t;
               c = bus.rsp_c;
            end
         end
      end
   endtask

   initial begin
      logic [63:0] c;
      int lat;
      int cnt;
      for (int i = 0; i < NREQ; i++) begin
         va[i] = 64'(i);
         vb[i] = 64'd0;
      end
      vv = '1;
      hs = '0;
      drive();
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_c", bus.rsp_c, 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      vv = '0;
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // all requesters valid, fixed operands
      for (int i = 0; i < NREQ; i++) begin
         va[i] = 64'(i + 10);
         vb[i] = 64'(i);
      end
      vv = '1;
      drive();
      for (int n = 0; n < 16; n++) begin
         cycle();
         chk("t2_grant", 64'(hs), 64'(1 << (n % NREQ)));
         if (bus.rsp_valid) chk("t2_c", bus.rsp_c, 64'd10);
      end
      drain();

      single(64'h010000000000000A, 64'h1000000000000005, c, lat);
      chk("t1_c", c, 64'h7100118000000006);
      chk("t1_lat", 64'(lat), 64'(LAT + 1));
      single(64'd3, 64'd5, c, lat);
      chk("t4_borrow", c, 64'h8000117FFFFFFFFF);
      single(64'd7, 64'd7, c, lat);
      chk("t4_equal", c, 64'd0);
      chk("t4_lat", 64'(lat), 64'(LAT + 1));
      single(64'hFFFFFFFFFFFFFFFF, 64'd0, c, lat);
      chk("t4_max", c, 64'hFFFFFFFFFFFFFFFF);

      // credit exhaustion with a stalled consumer
      drain();
      bus.rsp_ready = 1'b0;
      vv = '0;
      refresh(1'b0);
      cnt = 0;
      for (int n = 0; n < 14; n++) begin
         cycle();
         cnt += $countones(hs);
         refresh(1'b0);
      end
      chk("t3_hs_count", 64'(cnt), 64'(DEPTH));
      bus.rsp_ready = 1'b1;
      cycle();
      chk("t3_no_early_issue", 64'(hs), 64'd0);
      refresh(1'b0);
      cycle();
      chk("t3_resume", 64'(hs != 0), 64'd1);
      refresh(1'b0);

      // refill to full, then push and pop around the full mark
      bus.rsp_ready = 1'b0;
      for (int n = 0; n < 6; n++) begin
         cycle();
         refresh(1'b0);
      end
      for (int n = 0; n < 40; n++) begin
         bus.rsp_ready = 1'($urandom_range(0, 1));
         cycle();
         refresh(1'b0);
      end

      // reset with ops in flight and in the FIFO
      drain();
      bus.rsp_ready = 1'b0;
      vv = '0;
      refresh(1'b0);
      for (int n = 0; n < 5; n++) begin
         cycle();
         refresh(1'b0);
      end
      chk("t5_fifo_fill", 64'(fifo_q.size()), 64'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_req_ready", 64'(bus.req_ready), 64'd0);
      pipe_q.delete();
      fifo_q.delete();
      last = NREQ - 1;
      @(negedge clk);
      vv = '0;
      drive();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      hs = '0;
      refresh(1'b0);
      cycle();
      chk("t5_first_grant", 64'(hs), 64'h1);
      for (int n = 0; n < 12; n++) begin
         refresh(1'b0);
         cycle();
      end

      // random traffic
      drain();
      for (int n = 0; n < 300; n++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         refresh(1'b1);
         cycle();
      end
      drain();
      qH = {$urandom, $urandom};
      for (int n = 0; n < 200; n++) begin
         bus.rsp_ready = ($urandom_range(0, 2) != 0);
         refresh(1'b1);
         cycle();
      end
      drain();

      $display("%0d/%0d checks passed", ntot - nfail, ntot);
      $finish;
   end
endmodule
